fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Producer side of the instruction register: fetches 32-bit words from instruction memory and
// presents them as ir/ir_pc to the decoder with a valid/ready handshake. Owns the PC: sequential
// +4 advance, redirects from the control unit, and fetch faults (misaligned target, access error).
// At most one memory request outstanding. Memory responses return in order.
// PARAMETERS
// RESET_PC   32'h0000_0000   PC of the first fetch after reset; must be 4-byte aligned
// PORTS
// clk             in   1    clock, all state on rising edge
// rst             in   1    asynchronous, active-high reset
// redirect_valid  in   1    load redirect_pc as the new PC and abandon the current fetch
// redirect_pc     in   32   redirect target
// mem_req_valid   out  1    fetch request valid
// mem_req_ready   in   1    memory accepts the request this cycle
// mem_req_addr    out  32   fetch address; always the current PC
// mem_rsp_valid   in   1    response valid; one per accepted request
// mem_rsp_data    in   32   fetched instruction word
// mem_rsp_error   in   1    access fault for this response
// ir              out  `INST_MASK   instruction to the decoder
// ir_pc           out  32   address of ir
// ir_valid        out  1    ir/ir_pc are valid
// ir_ready        in   1    control unit consumes ir this cycle
// fault           out  1    fetch fault pending; sticky until redirect
// fault_cause     out  2    fault_cause_t: NONE=0, MISALIGNED=1, ACCESS=2
// BEHAVIOUR
// - Reset values: state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, mem_req_valid=0, fault=0,
//   fault_cause=NONE. Reset mid-transaction abandons it. Memory must also be reset.
// - States: IDLE -> REQ (unconditional, 1 cycle after reset release).
//   REQ: mem_req_valid=1, addr=pc. On accept (valid&ready), go to WAIT.
//   WAIT: on mem_rsp_valid&!error, ir<=data, ir_pc<=pc, go to FULL. On error, go to FAULT with cause ACCESS.
//   FULL: ir_valid=1; ir/ir_pc stable. On ir_ready, pc<=pc+4 and go to REQ.
//   DRAIN: wait for the stale response, discard it (error ignored), then go to REQ.
//   FAULT: ir_valid=0, mem_req_valid=0, fault=1; leaves only on redirect.
// - Outputs: mem_req_valid is asserted only in REQ. ir_valid is asserted only in FULL.
// - Latency: accept at cycle N -> response at N+k (k>=1) -> ir_valid at N+k+1.
//   Back-to-back: ir_ready at cycle M -> mem_req_valid at M+1.
// - Request stability: addr is held while valid&!ready. The only exception is a redirect, which may change it.
// - Redirect has priority over every other event in every state except IDLE:
//   1) pc<=redirect_pc, ir_valid drops next cycle, fault clears.
//   2) If redirect_pc[1:0]!=0: go to FAULT with cause MISALIGNED and no memory access.
//   3) Otherwise, if the redirect arrives in WAIT without a response this cycle, or in REQ with an
//      accept this cycle: go to DRAIN.
//   4) Otherwise: go to REQ.
//   A response arriving in the same cycle as a redirect is discarded.
// - Redirect + ir_ready in FULL: redirect wins; the held ir is not advanced past, pc=redirect_pc.
// - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0, with no fault.
// - The RESET_PC alignment check is done at elaboration ($error if RESET_PC[1:0]!=0).
// STRUCTURE
// - Package fetch_pkg: fetch_state_t {IDLE,REQ,WAIT,FULL,DRAIN,FAULT}, fault_cause_t, INST_BYTES=4.
//   fault_cause_t is shared with the control unit's trap logic.
// - Widths come from `INST_MASK in constants.svh.
// - Single module; no sub-module. The PC register, FSM and IR register are all local.
// TESTING
// 1 Reset release, mem_req_ready=1, 1-cycle memory returning 32'h0000_2003 -> first req addr=RESET_PC;
//   ir=32'h0000_2003, ir_pc=0, ir_valid set 2 cycles after accept.
// 2 ir_ready held 1 over 4 fetches -> addrs 0,4,8,C; each ir held stable while ir_ready=0 (stall 3 cycles).
// 3 Redirect to 32'h100 while in WAIT; stale response arrives 2 cycles later -> stale data never on ir;
//   next req addr=32'h100.
// 4 Redirect to 32'h102 -> fault=1, cause=MISALIGNED, no mem_req_valid; redirect 32'h200 clears fault, fetches 32'h200.
// 5 mem_rsp_error=1 at pc=32'h40 -> fault=1, cause=ACCESS, ir_valid=0; state holds 20 cycles until redirect.
// 6 pc=32'hFFFF_FFFC consumed -> next addr 0. Also: rst asserted while in WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, fault causes and the instruction width macro.
`ifndef INST_MASK
`define INST_MASK 31:0
`endif

package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FULL,
    DRAIN,
    FAULT
  } fetch_state_t;

  // Also consumed by the control unit's trap logic; keep encodings stable.
  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    ACCESS     = 2'd2
  } fault_cause_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one memory request at a time and
// hands fetched words to the decoder through the ir valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [31:0]        mem_rsp_data,
  input  logic               mem_rsp_error,
  output logic [`INST_MASK]  ir,
  output logic [31:0]        ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               fault,
  output logic [1:0]         fault_cause
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be 4-byte aligned");
  end

  fetch_state_t      r_state;
  logic [31:0]       r_pc;
  logic [`INST_MASK] r_ir;
  logic [31:0]       r_ir_pc;
  logic              r_ir_valid;
  logic              r_mem_req_valid;
  logic              r_fault;
  fault_cause_t      r_cause;

  fetch_state_t      w_next;
  logic [31:0]       w_pc;
  fault_cause_t      w_cause;
  logic              w_load_ir;
  logic              w_accept;

  assign w_accept = r_mem_req_valid & mem_req_ready;

  // Redirect overrides everything outside IDLE; a request already accepted
  // (or still in flight) leaves a stale response that DRAIN must swallow.
  always_comb begin
    w_next    = r_state;
    w_pc      = r_pc;
    w_cause   = r_cause;
    w_load_ir = 1'b0;
    if (r_state == IDLE) begin
      w_next = REQ;
    end else if (redirect_valid) begin
      w_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        w_next  = FAULT;
        w_cause = MISALIGNED;
      end else begin
        w_cause = NONE;
        if ((r_state == WAIT && !mem_rsp_valid) || (r_state == REQ && w_accept))
          w_next = DRAIN;
        else
          w_next = REQ;
      end
    end else begin
      case (r_state)
        REQ:   if (w_accept) w_next = WAIT;
        WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_error) begin
              w_next  = FAULT;
              w_cause = ACCESS;
            end else begin
              w_next    = FULL;
              w_load_ir = 1'b1;
            end
          end
        end
        FULL: begin
          if (ir_ready) begin
            w_pc   = r_pc + INST_BYTES;
            w_next = REQ;
          end
        end
        DRAIN: if (mem_rsp_valid) w_next = REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_pc            <= RESET_PC;
      r_ir            <= '0;
      r_ir_pc         <= '0;
      r_ir_valid      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_fault         <= 1'b0;
      r_cause         <= NONE;
    end else begin
      r_state         <= w_next;
      r_pc            <= w_pc;
      r_cause         <= w_cause;
      r_mem_req_valid <= (w_next == REQ);
      r_ir_valid      <= (w_next == FULL);
      r_fault         <= (w_next == FAULT);
      if (w_load_ir) begin
        r_ir    <= mem_rsp_data;
        r_ir_pc <= r_pc;
      end
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_pc;
  assign ir            = r_ir;
  assign ir_pc         = r_ir_pc;
  assign ir_valid      = r_ir_valid;
  assign fault         = r_fault;
  assign fault_cause   = r_cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, transaction-level PC/fault model and directed scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_error;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        fault;
  logic [1:0]  fault_cause;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_error  (mem_rsp_error),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .fault          (fault),
    .fault_cause    (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every address holds a distinct word, so a stale word under a new ir_pc is detectable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_2003;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory and reference-model state (touched only by the negedge process,
  // except lat/err_addr which the stimulus sets away from negedge).
  int unsigned lat = 1;
  logic [31:0] err_addr = 32'h0000_0001;
  bit          pend;
  int unsigned cnt;
  logic [31:0] p_addr;
  int unsigned p_tag;
  int unsigned rsp_tag;
  int unsigned epoch;
  logic [31:0] m_pc;
  bit          m_fault;
  logic [1:0]  m_cause;

  always @(negedge clk) begin
    if (rst) begin
      pend          = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_error = 1'b0;
      m_pc          = RST_PC;
      m_fault       = 1'b0;
      m_cause       = 2'd0;
      epoch++;
    end else begin
      if (mem_req_valid) check("req_addr", mem_req_addr, m_pc);
      if (ir_valid) begin
        check("ir_pc", ir_pc, m_pc);
        check("ir_word", ir, mem_word(m_pc));
      end
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_cause", 32'(fault_cause), 32'(m_cause));
      if (m_fault) check("quiet_in_fault", 32'({mem_req_valid, ir_valid}), 32'd0);
      if (mem_req_valid && ir_valid) check("req_and_ir_exclusive", 32'd1, 32'd0);

      // memory: response presented to the coming edge
      mem_rsp_valid = 1'b0;
      mem_rsp_error = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(p_addr);
          mem_rsp_error = (p_addr == err_addr);
          rsp_tag       = p_tag;
          pend          = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        check("one_outstanding", 32'(pend), 32'd0);
        pend   = 1'b1;
        p_addr = mem_req_addr;
        p_tag  = epoch;
        cnt    = lat - 1;
      end

      // reference model: PC and fault flag as seen after the coming edge
      if (redirect_valid) begin
        m_pc    = redirect_pc;
        m_fault = (redirect_pc[1:0] != 2'b00);
        m_cause = m_fault ? 2'd1 : 2'd0;
        epoch++;
      end else if (ir_valid && ir_ready) begin
        m_pc = m_pc + 32'd4;
      end else if (mem_rsp_valid && mem_rsp_error && rsp_tag == epoch) begin
        m_fault = 1'b1;
        m_cause = 2'd2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name, input logic [31:0] exp_addr);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_accept_seen"}, 32'(ok), 32'd1);
    if (ok) check({name, "_addr"}, mem_req_addr, exp_addr);
  endtask

  task automatic wait_irv(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_ir);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_ir_valid_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({name, "_ir_pc"}, ir_pc, exp_pc);
      check({name, "_ir"}, ir, exp_ir);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b1;
    ir_ready       = 1'b0;
    #7;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_addr", mem_req_addr, RST_PC);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_ir_pc", ir_pc, 32'd0);
    check("rst_fault", 32'({fault, fault_cause}), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // 1: first fetch, 1-cycle memory, ir_valid two cycles after accept
    wait_accept("t1", 32'h0);
    c = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ir_valid) begin
        c = n;
        break;
      end
    end
    check("t1_accept_to_ir_valid", 32'(c), 32'd2);
    check("t1_ir", ir, 32'h0000_2003);
    check("t1_ir_pc", ir_pc, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t1_stall_ir", ir, 32'h0000_2003);
      check("t1_stall_valid", 32'(ir_valid), 32'd1);
    end
    tick();
    ir_ready = 1'b1;

    // 2: streaming with ir_ready held, then a 3-cycle stall on 0xC
    wait_accept("t2_a4", 32'h4);
    wait_accept("t2_a8", 32'h8);
    wait_accept("t2_aC", 32'hC);
    tick();
    ir_ready = 1'b0;
    wait_irv("t2_C", 32'hC, 32'hFFF3_000C);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t2_stall_ir", ir, 32'hFFF3_000C);
      check("t2_stall_ir_pc", ir_pc, 32'hC);
    end

    // 3: redirect while WAIT, stale response lands in DRAIN
    tick();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    lat = 3;
    wait_accept("t3_a10", 32'h10);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    lat = 1;
    tick();
    redirect_valid = 1'b0;
    wait_accept("t3_a100", 32'h100);
    wait_irv("t3_100", 32'h100, 32'hFEFF_0100);

    // 4: misaligned redirect faults without touching memory
    redirect(32'h102);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t4_fault", 32'(fault), 32'd1);
      check("t4_cause", 32'(fault_cause), 32'd1);
      check("t4_no_req", 32'(mem_req_valid), 32'd0);
    end
    redirect(32'h200);
    wait_accept("t4_a200", 32'h200);
    check("t4_fault_cleared", 32'(fault), 32'd0);
    wait_irv("t4_200", 32'h200, 32'hFDFF_0200);

    // 5: access error at 0x40 holds FAULT until redirect
    err_addr = 32'h40;
    redirect(32'h40);
    wait_accept("t5_a40", 32'h40);
    repeat (20) @(negedge clk);
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_cause", 32'(fault_cause), 32'd2);
    check("t5_no_ir", 32'(ir_valid), 32'd0);
    check("t5_no_req", 32'(mem_req_valid), 32'd0);
    redirect(32'hFFFF_FFFC);
    wait_accept("t5_aFFFC", 32'hFFFF_FFFC);
    check("t5_fault_cleared", 32'({fault, fault_cause}), 32'd0);
    wait_irv("t5_FFFC", 32'hFFFF_FFFC, 32'h0003_FFFC);

    // 6: PC wraps to 0; async reset while WAIT
    tick();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    lat = 3;
    wait_accept("t6_wrap", 32'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("t6_rst_addr", mem_req_addr, RST_PC);
    check("t6_rst_ir_valid", 32'(ir_valid), 32'd0);
    check("t6_rst_ir", ir, 32'd0);
    check("t6_rst_ir_pc", ir_pc, 32'd0);
    check("t6_rst_fault", 32'({fault, fault_cause}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    lat = 1;
    wait_accept("t6_after_rst", RST_PC);
    wait_irv("t6_after_rst", 32'h0, 32'h0000_2003);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
